// File: rtl/snake_step_sequencer.sv
// rtl/snake_step_sequencer.sv - button-to-direction latch and per-step segment sweep for snake movement logic
module snake_step_sequencer #(
  parameter int TICK_DIV = 2500000,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3,
  parameter int IDX_W    = 20
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             grow,
  output logic             Up,
  output logic             Down,
  output logic             Left,
  output logic             Right,
  output logic [IDX_W-1:0] bitNum,
  output logic             seg_valid,
  output logic             frame_done,
  output logic [7:0]       length
);

  localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0]       LEN_MAX  = 8'(MAX_LEN);
  localparam logic [7:0]       LEN_INIT = 8'(INIT_LEN);
  localparam logic [IDX_W-1:0] IDX_IDLE = '1;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SWEEP,
    ST_DONE
  } state_t;

  // direction vectors are {up, down, left, right}; all zero means no direction
  logic [3:0]       btn_raw;
  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [3:0]       pend_q, pend_d;
  logic [3:0]       dir_q, dir_d;
  logic [3:0]       opp_dir;
  logic             single_press;
  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] bitnum_q, bitnum_d;
  logic [7:0]       len_q, len_d;
  logic             grow_pend_q, grow_pend_d;

  assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Reversal is judged against the direction currently driven, not the pending one.
  always_comb begin
    opp_dir      = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};
    single_press = (sync2_q != 4'b0000) && ((sync2_q & (sync2_q - 4'd1)) == 4'b0000);
    pend_d       = pend_q;
    if (single_press && (sync2_q != opp_dir)) begin
      pend_d = sync2_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bitnum_d    = bitnum_q;
    dir_d       = dir_q;
    len_d       = len_q;
    grow_pend_d = grow_pend_q | grow;
    case (state_q)
      ST_WAIT: begin
        if (div_q == DIV_LAST) begin
          div_d    = '0;
          dir_d    = pend_q;
          bitnum_d = '0;
          state_d  = ST_SWEEP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SWEEP: begin
        if (bitnum_q == IDX_W'(len_q - 8'd1)) begin
          bitnum_d = IDX_IDLE;
          state_d  = ST_DONE;
        end else begin
          bitnum_d = bitnum_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_WAIT;
        // a grow arriving now is kept for the next frame rather than merged into this one
        if (grow_pend_q) begin
          if (len_q < LEN_MAX) begin
            len_d = len_q + 8'd1;
          end
          grow_pend_d = grow;
        end
      end
      default: begin
        state_d  = ST_WAIT;
        div_d    = '0;
        bitnum_d = IDX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_WAIT;
      div_q       <= '0;
      bitnum_q    <= IDX_IDLE;
      dir_q       <= 4'b0000;
      pend_q      <= 4'b0000;
      len_q       <= LEN_INIT;
      grow_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bitnum_q    <= bitnum_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      len_q       <= len_d;
      grow_pend_q <= grow_pend_d;
    end
  end

  assign {Up, Down, Left, Right} = dir_q;
  assign bitNum     = bitnum_q;
  assign seg_valid  = (state_q == ST_SWEEP);
  assign frame_done = (state_q == ST_DONE);
  assign length     = len_q;

endmodule
